// File: rtl/spi_slave_rx.sv
// SPI slave receive front-end with in-frame CRC-8 response.
// sck/csn/mosi are oversampled on clk. A frame is DATA_W payload bits MSB-first
// followed by an 8-bit CRC; the received word is presented with a one-cycle
// rx_valid pulse. A response word plus its CRC is shifted out on miso during
// the same frame.
module spi_slave_rx #(
    parameter int          DATA_W   = 24,
    parameter logic [7:0]  CRC_POLY = 8'h1D,
    parameter logic [7:0]  CRC_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_crc_ok,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [5:0] LAST_DATA = 6'(DATA_W - 1);
    localparam logic [5:0] DATA_END  = 6'(DATA_W);
    localparam logic [5:0] LAST_BIT  = 6'(DATA_W + 7);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_CRC  = 3'd2,
        S_DONE = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    // One serial CRC-8 step, MSB-first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        if (crc[7] ^ din) begin
            crc8_step = {crc[6:0], 1'b0} ^ CRC_POLY;
        end else begin
            crc8_step = {crc[6:0], 1'b0};
        end
    endfunction

    logic [1:0]        sck_sync_q, csn_sync_q, mosi_sync_q;
    logic              sck_prev_q, csn_prev_q;
    state_t            state_q, state_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [7:0]        rx_crc_q, rx_crc_d;
    logic [7:0]        crc_sh_q, crc_sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [7:0]        tx_crc_q, tx_crc_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_crc_ok_q, rx_crc_ok_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q;
    logic [7:0]        crc_tmp_s;

    // Edge strobes derived from the synchronized copies and their delayed copies.
    logic sck_rise_s, sck_fall_s, csn_fall_s, csn_rise_s, mosi_s;
    assign sck_rise_s = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall_s = ~sck_sync_q[1] & sck_prev_q;
    assign csn_fall_s = ~csn_sync_q[1] & csn_prev_q;
    assign csn_rise_s = csn_sync_q[1] & ~csn_prev_q;
    assign mosi_s     = mosi_sync_q[1];

    // State, synchronizers, shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= 2'b00;
            csn_sync_q  <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 6'd0;
            rx_sh_q     <= '0;
            rx_crc_q    <= CRC_INIT;
            crc_sh_q    <= 8'h00;
            tx_sh_q     <= '0;
            tx_crc_q    <= CRC_INIT;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_crc_ok_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck};
            csn_sync_q  <= {csn_sync_q[0], csn};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sck_prev_q  <= sck_sync_q[1];
            csn_prev_q  <= csn_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_crc_q    <= rx_crc_d;
            crc_sh_q    <= crc_sh_d;
            tx_sh_q     <= tx_sh_d;
            tx_crc_q    <= tx_crc_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_crc_ok_q <= rx_crc_ok_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Frame FSM next-state, receive deframing and transmit shifting.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_crc_d    = rx_crc_q;
        crc_sh_d    = crc_sh_q;
        tx_sh_d     = tx_sh_q;
        tx_crc_d    = tx_crc_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_crc_ok_d = rx_crc_ok_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        crc_tmp_s   = 8'h00;

        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                if (csn_fall_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 6'd0;
                    rx_crc_d  = CRC_INIT;
                    tx_sh_d   = tx_data;
                    tx_crc_d  = CRC_INIT;
                    miso_d    = tx_data[DATA_W-1];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (csn_rise_s) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (sck_fall_s) begin
                    rx_sh_d   = {rx_sh_q[DATA_W-2:0], mosi_s};
                    rx_crc_d  = crc8_step(rx_crc_q, mosi_s);
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == LAST_DATA) begin
                        state_d = S_CRC;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CRC: begin
                // A final fall coinciding with csn_rise still completes the frame.
                if (sck_fall_s && (bit_cnt_q == LAST_BIT)) begin
                    crc_sh_d  = {crc_sh_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = S_DONE;
                end else if (csn_rise_s) begin
                    state_d     = S_IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b0;
                end else if (sck_fall_s) begin
                    crc_sh_d  = {crc_sh_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                end else begin
                    state_d = S_CRC;
                end
            end
            S_DONE: begin
                miso_d      = 1'b0;
                rx_valid_d  = 1'b1;
                rx_data_d   = rx_sh_q;
                rx_crc_ok_d = (crc_sh_q == rx_crc_q);
                // csn may already have risen in this cycle; do not lose it.
                if (csn_rise_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                miso_d = 1'b0;
                if (csn_rise_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                miso_d  = 1'b0;
            end
        endcase

        // Transmit: bit k goes out on the rise after the k-th fall; the first
        // rise precedes any fall and leaves the already-driven MSB in place.
        if (((state_q == S_DATA) || (state_q == S_CRC)) && sck_rise_s && !csn_rise_s) begin
            if (bit_cnt_q == 6'd0) begin
                miso_d = miso_q;
            end else if (bit_cnt_q < DATA_END) begin
                tx_crc_d = crc8_step(tx_crc_q, tx_sh_q[DATA_W-1]);
                tx_sh_d  = {tx_sh_q[DATA_W-2:0], 1'b0};
                miso_d   = tx_sh_q[DATA_W-2];
            end else if (bit_cnt_q == DATA_END) begin
                crc_tmp_s = crc8_step(tx_crc_q, tx_sh_q[DATA_W-1]);
                tx_crc_d  = crc_tmp_s;
                miso_d    = crc_tmp_s[7];
            end else begin
                tx_crc_d = {tx_crc_q[6:0], 1'b0};
                miso_d   = tx_crc_q[6];
            end
        end else begin
            crc_tmp_s = 8'h00;
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_crc_ok = rx_crc_ok_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed self-checking bench for spi_slave_rx acting as the SPI master.
module tb_spi_slave_rx;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        csn = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic [23:0] tx_data = 24'h000000;
    logic [23:0] rx_data;
    logic        rx_valid;
    logic        rx_crc_ok;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fall_cyc = 0;
    int valid_cnt = 0, valid_hi = 0, valid_cyc = 0;
    int err_cnt = 0, err_hi = 0;
    logic valid_prev = 1'b0, err_prev = 1'b0;

    spi_slave_rx dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .csn       (csn),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_crc_ok (rx_crc_ok),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // System clock.
    always #5 clk = ~clk;

    // Cycle counter on the active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts pulses and high cycles of rx_valid and frame_err.
    always @(negedge clk) begin
        if (rx_valid) valid_hi <= valid_hi + 1;
        if (rx_valid && !valid_prev) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (frame_err) err_hi <= err_hi + 1;
        if (frame_err && !err_prev) err_cnt <= err_cnt + 1;
        valid_prev <= rx_valid;
        err_prev   <= frame_err;
    end

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8_model(input logic [23:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 23; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = (c << 1) ^ 8'h1D;
            else             c = c << 1;
        end
        return c;
    endfunction

    // Master transfer: bits sent MSB-first from bits[39]; miso sampled at each fall.
    // rst_at >= 0 asserts reset before that bit and drops csn while in reset.
    task automatic spi_xfer(input logic [39:0] bits, input int nbits, input int rst_at,
                            output logic [39:0] miso_bits);
        bit stop;
        stop = 1'b0;
        miso_bits = '0;
        @(negedge clk);
        csn = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits && !stop; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                csn = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                stop = 1'b1;
            end else begin
                mosi = bits[39-i];
                sck  = 1'b1;
                repeat (HALF) @(negedge clk);
                miso_bits[39-i] = miso;
                sck = 1'b0;
                last_fall_cyc = cyc;
                repeat (HALF) @(negedge clk);
            end
        end
        csn  = 1'b1;
        mosi = 1'b0;
        repeat (4 * HALF) @(negedge clk);
    endtask

    logic [39:0] mb;
    int v0, vh0, e0, eh0;
    logic [7:0] c_ff;

    initial begin
        // Reset with sck toggling and csn low.
        rst = 1'b1;
        csn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sck = ~sck;
        end
        @(negedge clk);
        sck = 1'b0;
        csn = 1'b1;
        @(negedge clk);
        check_eq("reset_outputs", {rx_valid, rx_crc_ok, frame_err, miso, rx_data},
                 {4'b0000, 24'h000000});
        check_eq("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("idle_no_valid", valid_cnt, 0);
        check_eq("idle_busy", busy, 1'b0);

        // Good all-zero frame with the known CRC, all-zero response.
        tx_data = 24'h000000;
        v0 = valid_cnt; vh0 = valid_hi;
        spi_xfer({24'h000000, 8'h0E, 8'h00}, 32, -1, mb);
        check_eq("good_valid_cnt", valid_cnt - v0, 1);
        check_eq("good_valid_width", valid_hi - vh0, 1);
        check_eq("good_rx_data", rx_data, 24'h000000);
        check_eq("good_crc_ok", rx_crc_ok, 1'b1);
        check_eq("good_latency", valid_cyc - last_fall_cyc, 4);
        check_eq("tx_zero_miso", mb[39:8], {24'h000000, 8'h0E});

        // Bad CRC frame; response 0xFFFFFF.
        tx_data = 24'hFFFFFF;
        c_ff = crc8_model(24'hFFFFFF);
        v0 = valid_cnt;
        spi_xfer({24'hA5A5A5, crc8_model(24'hA5A5A5) ^ 8'h01, 8'h00}, 32, -1, mb);
        check_eq("bad_valid_cnt", valid_cnt - v0, 1);
        check_eq("bad_rx_data", rx_data, 24'hA5A5A5);
        check_eq("bad_crc_ok", rx_crc_ok, 1'b0);
        check_eq("tx_ones_data", mb[39:16], 24'hFFFFFF);
        check_eq("tx_ones_crc", mb[15:8], c_ff);

        // Abort after 17 bits.
        v0 = valid_cnt; e0 = err_cnt; eh0 = err_hi;
        spi_xfer({24'h123456, 8'h00, 8'h00}, 17, -1, mb);
        check_eq("abort_err_cnt", err_cnt - e0, 1);
        check_eq("abort_err_width", err_hi - eh0, 1);
        check_eq("abort_no_valid", valid_cnt - v0, 0);
        check_eq("abort_rx_held", rx_data, 24'hA5A5A5);
        check_eq("abort_ok_held", rx_crc_ok, 1'b0);
        check_eq("abort_busy", busy, 1'b0);

        // Recovery frame.
        v0 = valid_cnt; e0 = err_cnt;
        spi_xfer({24'h123456, crc8_model(24'h123456), 8'h00}, 32, -1, mb);
        check_eq("recov_valid_cnt", valid_cnt - v0, 1);
        check_eq("recov_rx_data", rx_data, 24'h123456);
        check_eq("recov_crc_ok", rx_crc_ok, 1'b1);
        check_eq("recov_no_err", err_cnt - e0, 0);

        // 40-bit overrun burst.
        v0 = valid_cnt; vh0 = valid_hi; e0 = err_cnt;
        spi_xfer({24'hC3C3C3, crc8_model(24'hC3C3C3), 8'hFF}, 40, -1, mb);
        check_eq("ovr_valid_cnt", valid_cnt - v0, 1);
        check_eq("ovr_valid_width", valid_hi - vh0, 1);
        check_eq("ovr_rx_data", rx_data, 24'hC3C3C3);
        check_eq("ovr_crc_ok", rx_crc_ok, 1'b1);
        check_eq("ovr_no_err", err_cnt - e0, 0);

        // Reset at bit 10 of a frame.
        v0 = valid_cnt; e0 = err_cnt;
        spi_xfer({24'h5A5A5A, crc8_model(24'h5A5A5A), 8'h00}, 32, 10, mb);
        check_eq("mrst_no_valid", valid_cnt - v0, 0);
        check_eq("mrst_no_err", err_cnt - e0, 0);
        check_eq("mrst_rx_cleared", rx_data, 24'h000000);
        check_eq("mrst_busy", busy, 1'b0);

        // Frame after the mid-frame reset.
        tx_data = 24'h000000;
        v0 = valid_cnt;
        spi_xfer({24'h0F0F0F, crc8_model(24'h0F0F0F), 8'h00}, 32, -1, mb);
        check_eq("post_valid_cnt", valid_cnt - v0, 1);
        check_eq("post_rx_data", rx_data, 24'h0F0F0F);
        check_eq("post_crc_ok", rx_crc_ok, 1'b1);
        check_eq("post_latency", valid_cyc - last_fall_cyc, 4);
        check_eq("post_miso", mb[39:8], {24'h000000, 8'h0E});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
